// File: rtl/vmx_ctrl_stream_tx_if.sv
// Bundles the command-push, packet-control and AXI4-Stream signals of vmx_ctrl_stream_tx.
// master: the view from vmx_ctrl_stream_tx itself. slave: the view from the producer and the engine side.
// Clock and reset are not in the bundle; they stay plain ports on the block.
interface vmx_ctrl_stream_tx_if #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_FIFO_DEPTH_LOG2    = 4,
    parameter int C_PKT_LEN_WIDTH      = 8
);
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   cmd_wdata;
    logic                              cmd_wvalid;
    logic                              cmd_wready;
    logic                              pkt_start;
    logic [C_PKT_LEN_WIDTH-1:0]        pkt_len;
    logic                              pkt_busy;
    logic                              pkt_done;
    logic                              pkt_err;
    logic [C_FIFO_DEPTH_LOG2:0]        fifo_level;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_ctrl_tdata;
    logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_ctrl_tstrb;
    logic                              m_axis_ctrl_tlast;
    logic                              m_axis_ctrl_tvalid;
    logic                              m_axis_ctrl_tready;

    modport master (
        input  cmd_wdata, cmd_wvalid, pkt_start, pkt_len, m_axis_ctrl_tready,
        output cmd_wready, pkt_busy, pkt_done, pkt_err, fifo_level,
               m_axis_ctrl_tdata, m_axis_ctrl_tstrb, m_axis_ctrl_tlast, m_axis_ctrl_tvalid
    );

    modport slave (
        output cmd_wdata, cmd_wvalid, pkt_start, pkt_len, m_axis_ctrl_tready,
        input  cmd_wready, pkt_busy, pkt_done, pkt_err, fifo_level,
               m_axis_ctrl_tdata, m_axis_ctrl_tstrb, m_axis_ctrl_tlast, m_axis_ctrl_tvalid
    );
endinterface

// File: rtl/vmx_ctrl_stream_tx.sv
// Command FIFO plus AXI4-Stream master: streams N queued 32-bit control words as one tlast-framed packet.
// Latency: a word written into an empty FIFO during SEND shows up as tvalid two edges later. Sustained rate is 1 word/cycle.
// Backpressure: tready low holds the output register stable. A full FIFO drops cmd_wready.
// Ports: m_axis_ctrl_aclk/m_axis_ctrl_areset are the clock and the synchronous active-high reset.
//        bus (master) carries the command push (cmd_w*), packet control (pkt_*), fifo_level and the m_axis_ctrl_* stream.
// Option: define VMX_CTRL_TX_STORE_FWD_EN for store-and-forward. In that mode a start waits until the whole packet is queued.
module vmx_ctrl_stream_tx #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_FIFO_DEPTH_LOG2    = 4,
    parameter int C_PKT_LEN_WIDTH      = 8
) (
    input  logic                       m_axis_ctrl_aclk,
    input  logic                       m_axis_ctrl_areset,
    vmx_ctrl_stream_tx_if.master       bus
);
    localparam int DEPTH = 1 << C_FIFO_DEPTH_LOG2;
    localparam int AW    = C_FIFO_DEPTH_LOG2;
    localparam int LW    = C_FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_t;

    state_t                            state_q, state_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]                     wr_ptr, rd_ptr;
    logic [LW-1:0]                     count;
    logic [C_PKT_LEN_WIDTH-1:0]        rem_q;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   out_dat;
    logic                              out_vld, out_last;
    logic                              done_q, err_q;
    logic                              full, empty, push, pop, hs, final_hs;
    logic                              load_rem, err_set;
    logic [C_PKT_LEN_WIDTH-1:0]        load_len;
    logic [LW:0]                       level_sum;
    logic [LW-1:0]                     level;
`ifdef VMX_CTRL_TX_STORE_FWD_EN
    logic                              pend_q, pend_set, pend_clr, req;
    logic [C_PKT_LEN_WIDTH-1:0]        pend_len_q, req_len;
`endif

    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = bus.cmd_wvalid && !full;
    assign hs       = out_vld && bus.m_axis_ctrl_tready;
    assign final_hs = hs && out_last;

    // The level includes the word in the output register. It is clamped to the depth because a full FIFO
    // plus a loaded output register would otherwise read depth+1.
    assign level_sum = {1'b0, count} + (LW+1)'(out_vld);
    assign level     = (level_sum > (LW+1)'(DEPTH)) ? LW'(DEPTH) : level_sum[LW-1:0];

    assign bus.cmd_wready         = !full;
    assign bus.fifo_level         = level;
    assign bus.pkt_busy           = (state_q == ST_SEND);
    assign bus.pkt_done           = done_q;
    assign bus.pkt_err            = err_q;
    assign bus.m_axis_ctrl_tdata  = out_dat;
    assign bus.m_axis_ctrl_tstrb  = '1;
    assign bus.m_axis_ctrl_tlast  = out_last;
    assign bus.m_axis_ctrl_tvalid = out_vld;

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        load_rem = 1'b0;
        load_len = bus.pkt_len;
        err_set  = 1'b0;
`ifdef VMX_CTRL_TX_STORE_FWD_EN
        pend_set = 1'b0;
        pend_clr = 1'b0;
        req      = 1'b0;
        req_len  = bus.pkt_len;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef VMX_CTRL_TX_STORE_FWD_EN
                // A latched request takes priority. New starts are ignored while one is pending.
                if (pend_q) begin
                    req     = 1'b1;
                    req_len = pend_len_q;
                end else if (bus.pkt_start) begin
                    if (bus.pkt_len == '0 || 32'(bus.pkt_len) > DEPTH) begin
                        err_set = 1'b1;
                    end else begin
                        req = 1'b1;
                    end
                end
                if (req) begin
                    if (32'(level) >= 32'(req_len)) begin
                        state_d  = ST_SEND;
                        load_rem = 1'b1;
                        load_len = req_len;
                        pend_clr = 1'b1;
                    end else if (!pend_q) begin
                        pend_set = 1'b1;
                    end
                end
`else
                if (bus.pkt_start) begin
                    if (bus.pkt_len == '0) begin
                        err_set = 1'b1;
                    end else begin
                        state_d  = ST_SEND;
                        load_rem = 1'b1;
                    end
                end
`endif
            end
            ST_SEND: begin
                // Refill the output register when it is free or draining this cycle and words are still owed.
                pop = (!out_vld || hs) && !empty && (rem_q != '0);
                // The final word was loaded earlier, so a refill never coincides with the tlast handshake.
                if (final_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axis_ctrl_aclk) begin
        if (push) mem[wr_ptr] <= bus.cmd_wdata;
    end

    always_ff @(posedge m_axis_ctrl_aclk) begin
        if (m_axis_ctrl_areset) begin
            state_q  <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rem_q    <= '0;
            out_dat  <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef VMX_CTRL_TX_STORE_FWD_EN
            pend_q     <= 1'b0;
            pend_len_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= final_hs;
            err_q   <= err_set;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (load_rem)  rem_q <= load_len;
            else if (pop)  rem_q <= rem_q - 1'b1;
            if (pop) begin
                out_dat  <= mem[rd_ptr];
                out_last <= (rem_q == C_PKT_LEN_WIDTH'(1));
                out_vld  <= 1'b1;
            end else if (hs) begin
                out_vld  <= 1'b0;
                out_last <= 1'b0;
            end
`ifdef VMX_CTRL_TX_STORE_FWD_EN
            if (pend_clr) begin
                pend_q <= 1'b0;
            end else if (pend_set) begin
                pend_q     <= 1'b1;
                pend_len_q <= bus.pkt_len;
            end
`endif
        end
    end
endmodule
